wave_capture: RTL and testbench

WAVE_CAPTURE -- requirements
Module: wave_capture

---
 rtl/wave_capture_if.sv | 15 +
 rtl/wave_capture.sv | 114 +++++++++++
 tb/tb_wave_capture.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/wave_capture_if.sv
// Sample-in and read-out signal bundle for wave_capture.
// Handshake: sample_in is taken when sample_valid=1. rd_data is popped on a cycle with
// rd_valid=1 and rd_ready=1. While rd_valid=1 and rd_ready=0, rd_data and rd_valid hold.
interface wave_capture_if;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic       rd_ready;
    logic       rd_valid;
    logic [7:0] rd_data;

    modport master (output sample_in, output sample_valid, output rd_ready,
                    input  rd_valid,  input  rd_data);
    modport slave  (input  sample_in, input  sample_valid, input  rd_ready,
                    output rd_valid,  output rd_data);
endinterface

// File: rtl/wave_capture.sv
// Triggered sample capture: arm, wait for counter_in==trigger_value, buffer CAP_LEN
// samples in a FIFO, then wait for the consumer to drain it.
module wave_capture #(
    parameter int DEPTH   = 16,
    parameter int CAP_LEN = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        arm,
    input  logic [31:0] counter_in,
    input  logic [31:0] trigger_value,
    wave_capture_if.slave bus,
    output logic [1:0]  state,
    output logic        overflow,
    output logic        capture_done
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } state_e;

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [15:0]   LAST_CNT = 16'(CAP_LEN);

    state_e          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q, count_d;
    logic [15:0]     smp_cnt_q, smp_cnt_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      mem_q [DEPTH];

    logic fifo_empty, fifo_full, pop, take, push, drop;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);
    assign pop        = !fifo_empty && bus.rd_ready;
    assign take       = (state_q == CAPTURE) && bus.sample_valid;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push       = take && (!fifo_full || pop);
    assign drop       = take && fifo_full && !pop;

    always_comb begin
        state_d      = state_q;
        smp_cnt_d    = smp_cnt_q;
        overflow_d   = overflow_q;
        capture_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d    = ARMED;
                    overflow_d = 1'b0;
                    smp_cnt_d  = '0;
                end
            end
            ARMED: begin
                if (counter_in == trigger_value) state_d = CAPTURE;
            end
            CAPTURE: begin
                if (take) begin
                    smp_cnt_d = smp_cnt_q + 16'd1;
                    if (drop) overflow_d = 1'b1;
                    if (smp_cnt_q + 16'd1 == LAST_CNT) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    capture_done = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            smp_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            smp_cnt_q  <= smp_cnt_d;
            overflow_q <= overflow_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    // Storage carries no reset; emptiness is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.sample_in;
    end

    assign bus.rd_valid = !fifo_empty;
    assign bus.rd_data  = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
    assign state        = state_q;
    assign overflow     = overflow_q;
endmodule

// File: tb/tb_wave_capture.sv
// Randomized bench for wave_capture: a queue-based reference model predicts buffered
// samples and status; a separate negedge monitor pops and compares.
module tb_wave_capture;
  localparam int DEPTH   = 16;
  localparam int CAP_LEN = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        arm = 1'b0;
  logic [31:0] counter_in = 32'd0;
  logic [31:0] trigger_value = 32'd0;
  logic [1:0]  state;
  logic        overflow;
  logic        capture_done;

  wave_capture_if bus_if ();

  wave_capture #(.DEPTH(DEPTH), .CAP_LEN(CAP_LEN)) dut (
    .clk(clk),
    .reset(reset),
    .arm(arm),
    .counter_in(counter_in),
    .trigger_value(trigger_value),
    .bus(bus_if.slave),
    .state(state),
    .overflow(overflow),
    .capture_done(capture_done)
  );

  // clock
  always #5 clk = ~clk;

  // reference model state
  logic [7:0] exp_q[$];
  int  m_phase = 0;
  bit  m_ovf = 1'b0;
  int  m_cnt = 0;
  bit  pop_pending = 1'b0;
  bit  ever_pushed = 1'b0;
  bit  m_was_empty;
  int  done_pulses = 0;
  int  reads = 0;
  int  errors = 0;
  int  checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: phases 0 idle, 1 waiting for trigger, 2 collecting, 3 draining
  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
      m_phase = 0; m_ovf = 1'b0; m_cnt = 0; pop_pending = 1'b0; ever_pushed = 1'b0;
    end else begin
      m_was_empty = (exp_q.size() == 0) && !pop_pending;
      case (m_phase)
        0: if (arm) begin m_phase = 1; m_ovf = 1'b0; m_cnt = 0; end
        1: if (counter_in == trigger_value) m_phase = 2;
        2: if (bus_if.sample_valid) begin
             m_cnt++;
             if (exp_q.size() < DEPTH) begin
               exp_q.push_back(bus_if.sample_in);
               ever_pushed = 1'b1;
             end else m_ovf = 1'b1;
             if (m_cnt == CAP_LEN) m_phase = 3;
           end
        3: if (m_was_empty) m_phase = 0;
        default: m_phase = 0;
      endcase
      pop_pending = 1'b0;
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      check("state", 32'(state), 32'(m_phase));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("capture_done", 32'(capture_done), 32'(m_phase == 3 && exp_q.size() == 0));
      check("rd_valid", 32'(bus_if.rd_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("rd_data", 32'(bus_if.rd_data), 32'(exp_q[0]));
        if (bus_if.rd_ready) begin
          void'(exp_q.pop_front());
          pop_pending = 1'b1;
          reads++;
        end
      end else if (!ever_pushed) begin
        check("rd_data_idle_zero", 32'(bus_if.rd_data), 32'h0);
      end
      if (capture_done) done_pulses++;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    counter_in = counter_in + 32'd1;
  endtask

  // ready_mode: 0 always ready, 1 ready only when draining, 2 random, 3 ready once full
  task automatic run_capture(input int ready_mode, input bit rand_valid, input bit arm_noise);
    int  start_done;
    int  start_reads;
    bit  ready_latch;
    bit  finished;
    start_done  = done_pulses;
    start_reads = reads;
    ready_latch = 1'b0;
    finished    = 1'b0;
    tick();
    arm = 1'b1;
    trigger_value = counter_in + 32'd4;
    for (int n = 0; n < 400; n++) begin
      tick();
      if (done_pulses > start_done && m_phase == 0) begin
        finished = 1'b1;
        break;
      end
      arm = arm_noise ? ($urandom_range(0, 5) == 0) : 1'b0;
      bus_if.sample_in    = 8'($urandom);
      bus_if.sample_valid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (exp_q.size() >= DEPTH) ready_latch = 1'b1;
      case (ready_mode)
        0: bus_if.rd_ready = 1'b1;
        1: bus_if.rd_ready = (m_phase == 3);
        2: bus_if.rd_ready = ($urandom_range(0, 2) != 0);
        default: bus_if.rd_ready = ready_latch || (m_phase == 3);
      endcase
    end
    arm = 1'b0;
    bus_if.sample_valid = 1'b0;
    bus_if.rd_ready = 1'b0;
    check("capture_finished", 32'(finished), 32'd1);
    check("done_pulse_count", 32'(done_pulses - start_done), 32'd1);
    if (ready_mode == 1) check("reads_after_overflow", 32'(reads - start_reads), 32'(DEPTH));
    if (ready_mode == 0 || ready_mode == 3)
      check("reads_full_capture", 32'(reads - start_reads), 32'(CAP_LEN));
  endtask

  task automatic reset_pulse();
    bus_if.sample_valid = 1'b0;
    bus_if.rd_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    m_phase = 0; m_ovf = 1'b0; m_cnt = 0; pop_pending = 1'b0; ever_pushed = 1'b0;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_rd_valid", 32'(bus_if.rd_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_capture_done", 32'(capture_done), 32'd0);
    check("rst_rd_data", 32'(bus_if.rd_data), 32'd0);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    int guard;
    bus_if.sample_in = 8'h00;
    bus_if.sample_valid = 1'b0;
    bus_if.rd_ready = 1'b0;
    #12;
    check("init_state", 32'(state), 32'd0);
    check("init_rd_valid", 32'(bus_if.rd_valid), 32'd0);
    check("init_rd_data", 32'(bus_if.rd_data), 32'd0);
    check("init_overflow", 32'(overflow), 32'd0);
    check("init_capture_done", 32'(capture_done), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) tick();

    run_capture(0, 1'b0, 1'b0);   // straight capture, consumer always ready
    check("ovf_clean_capture", 32'(overflow), 32'd0);
    run_capture(1, 1'b0, 1'b0);   // consumer stalled: overflow from sample 17
    check("ovf_stalled_capture", 32'(overflow), 32'd1);
    run_capture(3, 1'b0, 1'b0);   // push and pop together on a full FIFO
    check("ovf_full_pushpop", 32'(overflow), 32'd0);
    for (int r = 0; r < 4; r++) run_capture(2, 1'b1, 1'b1);

    // arm held two cycles, trigger never matches, second arm ignored
    tick();
    arm = 1'b1;
    trigger_value = counter_in - 32'd10;
    tick();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    bus_if.sample_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      tick();
      bus_if.sample_in = 8'($urandom);
      arm = (n == 10);
    end
    check("armed_hold_state", 32'(state), 32'd1);
    check("armed_no_samples", 32'(bus_if.rd_valid), 32'd0);
    reset_pulse();
    repeat (3) tick();

    // reset mid-capture with five samples buffered
    tick();
    arm = 1'b1;
    trigger_value = counter_in + 32'd3;
    guard = 0;
    tick();
    arm = 1'b0;
    bus_if.sample_valid = 1'b1;
    while (exp_q.size() < 5 && guard < 40) begin
      bus_if.sample_in = 8'($urandom);
      tick();
      guard++;
    end
    check("five_buffered_reached", 32'(exp_q.size()), 32'd5);
    check("five_buffered_state", 32'(state), 32'd2);
    reset_pulse();
    for (int n = 0; n < 6; n++) begin
      tick();
      arm = 1'b0;
    end
    check("post_reset_idle", 32'(state), 32'd0);
    run_capture(0, 1'b0, 1'b0);   // recovers cleanly after reset

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
